// File: rtl/mem_block_fetcher_pkg.sv
// rtl/mem_block_fetcher_pkg.sv - local types for the block fetcher
package mem_block_fetcher_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } fsm_t;

endpackage

// File: rtl/sys.sv
// rtl/sys.sv - shared memory-port types and helpers
package sys;

  // Encoded transfer size is bytes-1; a full 32-bit word is 3.
  localparam logic [1:0] mem_req_size_word = 2'd3;

  typedef struct packed {
    logic        en;
    logic [31:0] addr;
    logic [1:0]  size;
  } mem_read_req_t;

  typedef struct packed {
    logic        done;
    logic [31:0] data;
  } mem_read_rsp_t;

  localparam mem_read_req_t mem_read_req_rst = '{en: 1'b0, addr: 32'h0, size: 2'h0};

  // Clear the offset bits of a byte address; size must be a power of two.
  function automatic logic [31:0] blk_align(input logic [31:0] addr, input int unsigned size);
    return addr & ~(size - 1);
  endfunction

endpackage

// File: rtl/mem_block_fetcher_rr_arbiter.sv
// rtl/mem_block_fetcher_rr_arbiter.sv - combinational round-robin channel picker
module mem_block_fetcher_rr_arbiter #(
  parameter int CH_CNT = 2,
  parameter int IW     = 1
) (
  input  logic [CH_CNT-1:0] req,
  input  logic [IW-1:0]     ptr,
  output logic [CH_CNT-1:0] grant,
  output logic [IW-1:0]     idx
);

  // Pick the requester closest to ptr going upward with wrap; ptr itself is first.
  always_comb begin : arb_search
    int best_d;
    int d;
    grant  = '0;
    idx    = '0;
    best_d = CH_CNT;
    d      = 0;
    for (int j = 0; j < CH_CNT; j++) begin
      d = (j >= int'(ptr)) ? (j - int'(ptr)) : (j + CH_CNT - int'(ptr));
      if (req[j] && (d < best_d)) begin
        best_d   = d;
        grant    = '0;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/mem_block_fetcher.sv
// rtl/mem_block_fetcher.sv - multi-channel block reader over a word port (option: MEM_BLOCK_FETCHER_CRIT_FIRST_EN)
module mem_block_fetcher #(
  parameter int BLOCK_SIZE = 16,
  parameter int CH_CNT     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CH_CNT-1:0][31:0]      blk_req_addr,
  input  logic [CH_CNT-1:0]            blk_req_en,
  output logic [BLOCK_SIZE*8-1:0]      blk_rsp_data,
  output logic [CH_CNT-1:0]            blk_rsp_done,
  output sys::mem_read_req_t           mem_req,
  input  sys::mem_read_rsp_t           mem_rsp
);

  import sys::*;
  import mem_block_fetcher_pkg::*;

  localparam int BEATS = BLOCK_SIZE / 4;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IW    = (CH_CNT > 1) ? $clog2(CH_CNT) : 1;

  fsm_t              state;
  logic [BW-1:0]     beat;
  logic [BW-1:0]     cur_word;
  logic [BW-1:0]     nxt_word;
  logic [BW-1:0]     start_word;
  logic [31:0]       base;
  logic [31:0]       req_addr_sel;
  logic [31:0]       req_base;
  logic [IW-1:0]     gnt_idx;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     rr_next;
  logic [IW-1:0]     arb_idx;
  logic [CH_CNT-1:0] arb_grant;
  logic              arb_valid;

  mem_block_fetcher_rr_arbiter #(
    .CH_CNT (CH_CNT),
    .IW     (IW)
  ) u_arb (
    .req   (blk_req_en),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  // Request decode for the winning channel and the word/pointer successors.
  always_comb begin
    arb_valid    = |arb_grant;
    req_addr_sel = blk_req_addr[arb_idx];
    req_base     = blk_align(req_addr_sel, BLOCK_SIZE);
`ifdef MEM_BLOCK_FETCHER_CRIT_FIRST_EN
    start_word   = BW'((req_addr_sel >> 2) & 32'(BEATS - 1));
`else
    start_word   = '0;
`endif
    nxt_word     = (cur_word == BW'(BEATS - 1)) ? '0 : cur_word + BW'(1);
    rr_next      = (gnt_idx == IW'(CH_CNT - 1)) ? '0 : gnt_idx + IW'(1);
  end

  // Transfer FSM: grant, issue BEATS word reads, then pulse done to the owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      beat         <= '0;
      cur_word     <= '0;
      base         <= '0;
      gnt_idx      <= '0;
      rr_ptr       <= '0;
      blk_rsp_data <= '0;
      blk_rsp_done <= '0;
      mem_req      <= mem_read_req_rst;
    end else begin
      blk_rsp_done <= '0;
      case (state)
        IDLE: begin
          if (arb_valid) begin
            base         <= req_base;
            gnt_idx      <= arb_idx;
            beat         <= '0;
            cur_word     <= start_word;
            mem_req.en   <= 1'b1;
            mem_req.addr <= req_base + (32'(start_word) << 2);
            mem_req.size <= mem_req_size_word;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_rsp.done) begin
            blk_rsp_data[int'(cur_word)*32 +: 32] <= mem_rsp.data;
            beat <= (beat == BW'(BEATS - 1)) ? '0 : beat + BW'(1);
            if (!blk_req_en[gnt_idx]) begin
              // Requester withdrew: finish this beat quietly, keep the rr pointer.
              mem_req.en <= 1'b0;
              state      <= IDLE;
            end else if (beat == BW'(BEATS - 1)) begin
              mem_req.en            <= 1'b0;
              blk_rsp_done[gnt_idx] <= 1'b1;
              state                 <= RESP;
            end else begin
              cur_word     <= nxt_word;
              mem_req.addr <= base + (32'(nxt_word) << 2);
            end
          end
        end
        RESP: begin
          rr_ptr <= rr_next;
          state  <= IDLE;
        end
        default: begin
          mem_req.en <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_block_fetcher.sv
// tb/tb_mem_block_fetcher.sv - scoreboard bench for mem_block_fetcher
module tb_mem_block_fetcher;
  import sys::*;

  localparam int BLOCK_SIZE = 16;
  localparam int CH_CNT     = 2;
  localparam int BEATS      = BLOCK_SIZE / 4;
  localparam int DW         = BLOCK_SIZE * 8;
  localparam int CW         = (DW > 40) ? DW : 40;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic [CH_CNT-1:0][31:0] blk_req_addr;
  logic [CH_CNT-1:0]       blk_req_en;
  logic [DW-1:0]           blk_rsp_data;
  logic [CH_CNT-1:0]       blk_rsp_done;
  mem_read_req_t           mem_req;
  mem_read_rsp_t           mem_rsp;

  mem_block_fetcher #(
    .BLOCK_SIZE (BLOCK_SIZE),
    .CH_CNT     (CH_CNT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .blk_req_addr (blk_req_addr),
    .blk_req_en   (blk_req_en),
    .blk_rsp_data (blk_rsp_data),
    .blk_rsp_done (blk_rsp_done),
    .mem_req      (mem_req),
    .mem_rsp      (mem_rsp)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int beats_seen = 0;
  int last_beat_cyc = 0;
  int model_ptr = 0;
  int mem_mode = 0;
  int wait_cnt = 0;
  int cur_delay = 0;
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic [31:0] pa [2][8];

  typedef struct {
    int            ch;
    logic [DW-1:0] data;
    int            cyc;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] exp_addr[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a;
  endfunction

  // Word memory: done after a programmable number of wait cycles (0 = same cycle).
  always_comb begin
    logic d;
    d = mem_req.en && (wait_cnt >= cur_delay);
    mem_rsp.done = d;
    mem_rsp.data = d ? mem_data(mem_req.addr) : 32'h0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt  <= 0;
      cur_delay <= 0;
    end else if (mem_req.en) begin
      if (mem_rsp.done) begin
        wait_cnt  <= 0;
        cur_delay <= (mem_mode < 0) ? int'($urandom_range(0, 3)) : mem_mode;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end
  end

  // Reference: block fetch = BEATS word reads starting at the chosen word, wrapping; layout natural.
  function automatic void push_txn(input int ch, input logic [31:0] a, input int nbeats,
                                   input bit complete, input int ecyc);
    logic [31:0]   base;
    logic [DW-1:0] blk;
    int            st;
    base = a & ~32'(BLOCK_SIZE - 1);
    st   = 0;
`ifdef MEM_BLOCK_FETCHER_CRIT_FIRST_EN
    st = int'(a % BLOCK_SIZE) / 4;
`endif
    for (int k = 0; k < nbeats; k++)
      exp_addr.push_back(base + 32'(4 * ((st + k) % BEATS)));
    if (complete) begin
      blk = '0;
      for (int w = 0; w < BEATS; w++)
        blk[w*32 +: 32] = mem_data(base + 32'(4 * w));
      sb.push_back('{ch, blk, ecyc});
    end
  endfunction

  // Monitor: check every accepted beat and every done pulse against the queues.
  always @(negedge clk) begin
    if (rst) begin
      prev_wait = 1'b0;
    end else begin
      if (prev_wait) begin
        chk("req_en_hold", mem_req.en, 1);
        chk("req_addr_hold", mem_req.addr, prev_addr);
      end
      if (mem_req.en) chk("req_size", mem_req.size, 3);
      if (mem_req.en && mem_rsp.done) begin
        beats_seen++;
        last_beat_cyc = cyc;
        if (exp_addr.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got addr %0h want none", mem_req.addr);
        end else begin
          chk("beat_addr", mem_req.addr, exp_addr.pop_front());
        end
      end
      prev_wait = mem_req.en && !mem_rsp.done;
      prev_addr = mem_req.addr;
      if (blk_rsp_done != '0) begin
        chk("done_onehot", $onehot(blk_rsp_done), 1);
        chk("done_after_last_beat", cyc, last_beat_cyc + 1);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got %0h want none", blk_rsp_done);
        end else begin
          sb_t e;
          e = sb.pop_front();
          chk("done_channel", blk_rsp_done, 1 << e.ch);
          chk("rsp_data", blk_rsp_data, e.data);
          if (e.cyc >= 0) chk("done_latency", cyc, e.cyc);
        end
      end
    end
  end

  task automatic wait_done(input int ch);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (blk_rsp_done[ch] !== 1'b1 && n < 300);
    chk("done_seen", blk_rsp_done[ch], 1);
  endtask

  task automatic wait_beats(input int target);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (beats_seen < target && n < 300);
    chk("beats_reached", beats_seen >= target, 1);
  endtask

  task automatic single_txn(input int ch, input logic [31:0] a, input bit timed);
    push_txn(ch, a, BEATS, 1, timed ? cyc + BEATS + 1 : -1);
    blk_req_addr[ch] = a;
    blk_req_en[ch]   = 1'b1;
    wait_done(ch);
    @(posedge clk);
    #1;
    blk_req_en[ch] = 1'b0;
    model_ptr = (ch + 1) % CH_CNT;
  endtask

  task automatic drive_ch(input int ch, input int n);
    for (int j = 0; j < n; j++) begin
      blk_req_addr[ch] = pa[ch][j];
      blk_req_en[ch]   = 1'b1;
      wait_done(ch);
      @(posedge clk);
      #1;
    end
    blk_req_en[ch] = 1'b0;
  endtask

  // Both channels request back-to-back: service must alternate from model_ptr.
  task automatic dual_phase(input int n);
    for (int j = 0; j < n; j++) begin
      pa[0][j] = $urandom;
      pa[1][j] = $urandom;
    end
    for (int k = 0; k < 2 * n; k++) begin
      int ch;
      ch = (model_ptr + k) % 2;
      push_txn(ch, pa[ch][k / 2], BEATS, 1, -1);
    end
    fork
      drive_ch(0, n);
      drive_ch(1, n);
    join
  endtask

  task automatic abort_phase();
    int          b0;
    logic [31:0] a0;
    logic [31:0] a1;
    b0 = beats_seen;
    a0 = $urandom;
    a1 = $urandom;
    mem_mode = 3;
    push_txn(1, a1, 3, 0, -1);
    blk_req_addr[1] = a1;
    blk_req_en[1]   = 1'b1;
    @(posedge clk);
    #1;
    push_txn(0, a0, BEATS, 1, -1);
    blk_req_addr[0] = a0;
    blk_req_en[0]   = 1'b1;
    wait_beats(b0 + 2);
    @(posedge clk);
    #1;
    blk_req_en[1] = 1'b0;
    wait_beats(b0 + 3);
    @(negedge clk);
    chk("abort_idle_en", mem_req.en, 0);
    wait_done(0);
    @(posedge clk);
    #1;
    blk_req_en[0] = 1'b0;
    model_ptr = 1;
  endtask

  task automatic reset_phase();
    int          b0;
    logic [31:0] a;
    mem_mode = 2;
    a  = $urandom;
    b0 = beats_seen;
    push_txn(0, a, BEATS, 1, -1);
    blk_req_addr[0] = a;
    blk_req_en[0]   = 1'b1;
    wait_beats(b0 + 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_req_en", mem_req.en, 0);
    chk("midrst_req", mem_req, 0);
    chk("midrst_done", blk_rsp_done, 0);
    chk("midrst_data", blk_rsp_data, 0);
    sb.delete();
    exp_addr.delete();
    blk_req_en = '0;
    model_ptr  = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    blk_req_en   = '0;
    blk_req_addr = '0;
    mem_mode     = 0;
    rst          = 1'b1;
    #1;
    chk("rst_done", blk_rsp_done, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_data", blk_rsp_data, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    single_txn(0, 32'h0000_1007, 1'b1);
    single_txn(0, 32'h0000_2008, 1'b1);

    mem_mode = -1;
    repeat (8) single_txn(int'($urandom_range(0, 1)), $urandom, 1'b0);

    dual_phase(4);

    mem_mode = 3;
    single_txn(1, $urandom, 1'b0);

    abort_phase();
    reset_phase();

    mem_mode = -1;
    dual_phase(3);

    repeat (5) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    chk("addr_q_empty", exp_addr.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_block_fetcher.md
Name: mem_block_fetcher

Overview:
- Parametrised block-read engine that serves CH_CNT cache-side block requesters over one word-wide memory read port.
- Each block request is split into BLOCK_SIZE/4 sequential word reads.
- Word results are assembled little-endian into one block response.
- Round-robin arbitration between channels; sits between the I/D caches and the memory read interface, replacing fixed-size block reads.

Parameters:
- BLOCK_SIZE, 16, bytes per block; power of two, >= 4.
- CH_CNT, 2, number of requesting channels; >= 1.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- blk_req_addr  input  [CH_CNT][32]  per-channel block byte address; low log2(BLOCK_SIZE) bits ignored.
- blk_req_en  input  [CH_CNT]  per-channel request; held high until that channel's done.
- blk_rsp_data  output  BLOCK_SIZE*8  assembled block, shared by all channels; byte 0 in bits [7:0].
- blk_rsp_done  output  [CH_CNT]  one-cycle pulse to the granted channel; blk_rsp_data valid in that cycle.
- mem_req  output  sys::mem_read_req_t  downstream word read request.
- mem_rsp  input  sys::mem_read_rsp_t  downstream word read response.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high on rst.
- Reset values, applied immediately on rst assertion:
  - blk_rsp_data=0, blk_rsp_done=0, mem_req=sys::mem_read_req_rst.
  - FSM=IDLE, beat counter=0, rr pointer selects channel 0 first.
- IDLE:
  - If any blk_req_en is high, grant one channel round-robin: search starts at the channel after the last granted.
  - Latch base = addr with low log2(BLOCK_SIZE) bits cleared; latch the granted index; go ISSUE.
  - If none are high, stay in IDLE.
- ISSUE:
  - mem_req.en=1, mem_req.addr = base + 4*beat, mem_req.size = sys::mem_req_size_word (3, i.e. bytes-1).
  - addr and size are held stable until mem_rsp.done.
  - On mem_rsp.done, which may arrive in the same cycle as en: capture mem_rsp.data into the word slot for that beat, and advance the beat counter modulo BEATS=BLOCK_SIZE/4.
  - On the last beat, go RESP.
  - mem_req.en is low in every state except ISSUE.
- RESP:
  - blk_rsp_done[granted]=1 for exactly one cycle; blk_rsp_data holds the full block.
  - Next state is IDLE.
  - blk_rsp_data keeps its value until the next capture.
- Latency: with zero-wait memory, done rises BEATS+1 cycles after the cycle en is first sampled in IDLE (5 cycles at default).
- Handshake: the requester drops en on the edge at which it samples done. If en is still high in the following IDLE cycle, it is a new request.
- Abort: if the granted channel's en falls during ISSUE:
  - The current beat still completes (memory cannot be cancelled).
  - The FSM then returns to IDLE with no done pulse and no rr pointer change.
- mem_rsp.done outside ISSUE is ignored.
- Requests from other channels wait; they are never dropped.
- A reset mid-transfer abandons the transfer; no done is generated.
- Address arithmetic is 32-bit and wraps silently at 2^32.

Optional Feature:
- Macro: MEM_BLOCK_FETCHER_CRIT_FIRST_EN.
- When defined (critical-word-first):
  - The first beat is the word holding blk_req_addr, i.e. start = addr[log2(BLOCK_SIZE)-1:2].
  - Later beats wrap modulo BEATS.
  - Each word is still stored at its natural slot, so blk_rsp_data layout is unchanged.
- When undefined: beats always start at offset 0.

Decomposition:
- sys package additions:
  - mem_req_size_word (=3).
  - Function blk_align(addr, size).
- Local typedef: fsm_t {IDLE, ISSUE, RESP}.
- Sub-module rr_arbiter:
  - Inputs: CH_CNT request vector, pointer.
  - Outputs: one-hot grant and index.
  - Combinational; the pointer register lives in the parent.

Test Plan:
- Single request, ch0 addr 0x1007, zero-wait memory returning data=addr -> mem addrs 0x1000, 0x1004, 0x1008, 0x100C; done[0] pulses cycle 5; data = {0x100C, 0x1008, 0x1004, 0x1000}.
- ch0 and ch1 both requesting continuously -> grant order 0,1,0,1; no channel granted twice in a row.
- Memory with 3-cycle done delay -> mem_req.addr/en stable through each wait; done at cycle 1+4*4+... exactly after the 4th response plus one.
- Abort: ch1 en drops during beat 2 -> beat 2 completes, no done[1], FSM IDLE next cycle, ch0 then served.
- rst asserted during beat 1 -> mem_req.en low immediately (async), outputs zero; a fresh request afterward completes correctly.
- MEM_BLOCK_FETCHER_CRIT_FIRST_EN defined, addr 0x2008 -> issue order 0x2008, 0x200C, 0x2000, 0x2004; blk_rsp_data identical to the non-CWF case.
